// File: rtl/orb_kp_pkg.sv
// rtl/orb_kp_pkg.sv - shared widths, keypoint record and frame state for the keypoint arbiter
package orb_kp_pkg;

    localparam int KP_W  = 20;
    localparam int MOM_W = 21;
    localparam int CNT_W = 14;

    typedef struct packed {
        logic [KP_W-1:0]  kp;
        logic [MOM_W-1:0] m10;
        logic [MOM_W-1:0] m01;
    } kp_rec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/orb_kp_fifo.sv
// rtl/orb_kp_fifo.sv - show-ahead synchronous FIFO of keypoint records
module orb_kp_fifo
    import orb_kp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    wr_en,
    input  kp_rec_t wr_data,
    input  logic    rd_en,
    output kp_rec_t rd_data,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    kp_rec_t     mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/orb_kp_arbiter.sv
// rtl/orb_kp_arbiter.sv - merges two FAST corner streams into one keypoint port (ORB_KP_FIXED_PRIO_EN selects strict fast1 priority)
module orb_kp_arbiter
    import orb_kp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_KP     = 8191
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             frame_end,
    input  logic             s1_valid,
    output logic             s1_ready,
    input  logic [KP_W-1:0]  s1_kp,
    input  logic [MOM_W-1:0] s1_m10,
    input  logic [MOM_W-1:0] s1_m01,
    input  logic             s2_valid,
    output logic             s2_ready,
    input  logic [KP_W-1:0]  s2_kp,
    input  logic [MOM_W-1:0] s2_m10,
    input  logic [MOM_W-1:0] s2_m01,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [KP_W-1:0]  m_kp,
    output logic [MOM_W-1:0] m_m10,
    output logic [MOM_W-1:0] m_m01,
    output logic             m_src,
    output logic [CNT_W-1:0] num_kp1,
    output logic [CNT_W-1:0] num_kp2,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] MAX_KP_C = CNT_W'(MAX_KP);

    state_t           state;
    logic [CNT_W-1:0] acc_cnt;
    kp_rec_t          f1_rdata;
    kp_rec_t          f2_rdata;
    logic             f1_full, f1_empty, f2_full, f2_empty;
    logic             acc1, acc2, keep1, keep2, drop;
    logic             load, sel;

    // Sources may only push while the frame is running and their FIFO has room.
    always_comb begin
        s1_ready = (state == RUN) && !f1_full;
        s2_ready = (state == RUN) && !f2_full;
        acc1     = s1_valid && s1_ready;
        acc2     = s2_valid && s2_ready;
        // fast1 claims the last free slot first when both arrive together
        keep1    = acc1 && (acc_cnt < MAX_KP_C);
        keep2    = acc2 && ((acc_cnt + CNT_W'(keep1)) < MAX_KP_C);
        drop     = (acc1 && !keep1) || (acc2 && !keep2);
    end

    orb_kp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (keep1),
        .wr_data ('{kp: s1_kp, m10: s1_m10, m01: s1_m01}),
        .rd_en   (load && !sel),
        .rd_data (f1_rdata),
        .full    (f1_full),
        .empty   (f1_empty)
    );

    orb_kp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo2 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (keep2),
        .wr_data ('{kp: s2_kp, m10: s2_m10, m01: s2_m01}),
        .rd_en   (load && sel),
        .rd_data (f2_rdata),
        .full    (f2_full),
        .empty   (f2_empty)
    );

    assign load = (!m_valid || m_ready) && (!f1_empty || !f2_empty);

`ifdef ORB_KP_FIXED_PRIO_EN
    assign sel = f1_empty;
`else
    logic rr_last;

    assign sel = f1_empty ? 1'b1 : (f2_empty ? 1'b0 : ~rr_last);

    // Remember the last granted source; starts as fast2 so fast1 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) rr_last <= 1'b1;
        else if (load) rr_last <= sel;
    end
`endif

    // Output register: refills whenever empty or being consumed, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_kp    <= '0;
            m_m10   <= '0;
            m_m01   <= '0;
            m_src   <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_kp    <= sel ? f2_rdata.kp  : f1_rdata.kp;
            m_m10   <= sel ? f2_rdata.m10 : f1_rdata.m10;
            m_m01   <= sel ? f2_rdata.m01 : f1_rdata.m01;
            m_src   <= sel;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Frame sequencing, accepted-record count and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= RUN;
                    acc_cnt  <= '0;
                    overflow <= 1'b0;
                end
                RUN: begin
                    acc_cnt <= acc_cnt + CNT_W'(keep1) + CNT_W'(keep2);
                    if (drop) overflow <= 1'b1;
                    if (frame_end) state <= DRAIN;
                end
                DRAIN: if (f1_empty && f2_empty && !m_valid) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Per-source emitted counts, cleared when a new frame starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_kp1 <= '0;
            num_kp2 <= '0;
        end else if (state == IDLE && start) begin
            num_kp1 <= '0;
            num_kp2 <= '0;
        end else if (m_valid && m_ready) begin
            if (m_src) num_kp2 <= num_kp2 + CNT_W'(1);
            else       num_kp1 <= num_kp1 + CNT_W'(1);
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

endmodule
